// File: rtl/forward_unit.sv
// ---------------------------------------------------------------------------
// forward_unit
//   Operand-forwarding detector for the pipelined datapath. Compares the
//   execute-stage source registers (RA, RB) against the write-back
//   destination (WC) and raises out_A / out_B to select the forwarded value
//   over the register-file value. Two saturating event counters record the
//   number of cycles each forward select was asserted.
//
//   Optional build macro:
//     FU_ZERO_REG_EN - register index 0 is hardwired zero. A write to WC == 0
//                      never forwards, and so is never counted.
//
// Parameters
//   REG_W  register-index width (RA, RB, WC)
//   CNT_W  width of each forwarding event counter
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset (counters only)
//   OP_FU      in   operand-use mask: [1] reads RA, [0] reads RB
//   RA, RB     in   source register indices
//   WC         in   destination index of the writing instruction
//   W_RB       in   register-file write enable of the writing instruction
//   clr_cnt    in   synchronous clear of both counters
//   out_A      out  forward select, operand A (combinational)
//   out_B      out  forward select, operand B (combinational)
//   fwd_cnt_A  out  cycles with out_A = 1, saturating
//   fwd_cnt_B  out  cycles with out_B = 1, saturating
// ---------------------------------------------------------------------------
module forward_unit #(
    parameter int REG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       OP_FU,
    input  logic [REG_W-1:0] RA,
    input  logic [REG_W-1:0] RB,
    input  logic [REG_W-1:0] WC,
    input  logic             W_RB,
    input  logic             clr_cnt,
    output logic             out_A,
    output logic             out_B,
    output logic [CNT_W-1:0] fwd_cnt_A,
    output logic [CNT_W-1:0] fwd_cnt_B
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             wc_live;
    logic             fwd_a;
    logic             fwd_b;
    logic [CNT_W-1:0] cnt_a_d, cnt_a_q;
    logic [CNT_W-1:0] cnt_b_d, cnt_b_q;

    // A write-back is only a forwarding source if it actually writes the
    // register file, and (with the zero register) does not target index 0.
    always_comb begin
`ifdef FU_ZERO_REG_EN
        wc_live = W_RB & (WC != '0);
`else
        wc_live = W_RB;
`endif
        fwd_a = OP_FU[1] & wc_live & (RA == WC);
        fwd_b = OP_FU[0] & wc_live & (RB == WC);
    end

    // Clear takes priority over increment; increments stop at CNT_MAX.
    always_comb begin
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;
        if (clr_cnt) begin
            cnt_a_d = '0;
            cnt_b_d = '0;
        end else begin
            if (fwd_a && (cnt_a_q != CNT_MAX)) cnt_a_d = cnt_a_q + 1'b1;
            if (fwd_b && (cnt_b_q != CNT_MAX)) cnt_b_d = cnt_b_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_a_q <= '0;
            cnt_b_q <= '0;
        end else begin
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
        end
    end

    assign out_A     = fwd_a;
    assign out_B     = fwd_b;
    assign fwd_cnt_A = cnt_a_q;
    assign fwd_cnt_B = cnt_b_q;

endmodule

// File: tb/tb_forward_unit.sv
// ---------------------------------------------------------------------------
// tb_forward_unit
//   Self-checking bench for forward_unit. Counters are built narrow (CNT_W=8)
//   so saturation is reachable in a few hundred cycles. Expected values come
//   from a behavioural model: forwarding rules evaluated directly, counters
//   kept as plain integers clamped at the maximum.
// ---------------------------------------------------------------------------
module tb_forward_unit;

    localparam int REG_W   = 4;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic [1:0]       op_fu;
    logic [REG_W-1:0] ra;
    logic [REG_W-1:0] rb;
    logic [REG_W-1:0] wc;
    logic             w_rb;
    logic             clr_cnt;
    logic             out_a;
    logic             out_b;
    logic [CNT_W-1:0] fwd_cnt_a;
    logic [CNT_W-1:0] fwd_cnt_b;

    int n_checks = 0;
    int n_fail   = 0;

    // model counters
    int exp_cnt_a = 0;
    int exp_cnt_b = 0;

    // expected {out_A, out_B} per random cycle
    logic [1:0] exp_q[$];

    forward_unit #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .OP_FU    (op_fu),
        .RA       (ra),
        .RB       (rb),
        .WC       (wc),
        .W_RB     (w_rb),
        .clr_cnt  (clr_cnt),
        .out_A    (out_a),
        .out_B    (out_b),
        .fwd_cnt_A(fwd_cnt_a),
        .fwd_cnt_B(fwd_cnt_b)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic bit zero_reg_on();
`ifdef FU_ZERO_REG_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // An operand forwards when it is used, the writer writes, indices agree,
    // and the destination is not the hardwired zero register.
    function automatic bit model_fwd(input bit used, input bit wen,
                                     input int src, input int dst);
        if (!used || !wen) return 1'b0;
        if (zero_reg_on() && dst == 0) return 1'b0;
        return src == dst;
    endfunction

    function automatic logic [1:0] model_outs();
        return {model_fwd(op_fu[1], w_rb, int'(ra), int'(wc)),
                model_fwd(op_fu[0], w_rb, int'(rb), int'(wc))};
    endfunction

    // Advance model counters for one rising edge using the current inputs.
    task automatic model_edge();
        logic [1:0] o;
        o = model_outs();
        if (rst || clr_cnt) begin
            exp_cnt_a = 0;
            exp_cnt_b = 0;
        end else begin
            exp_cnt_a = (exp_cnt_a + int'(o[1]) > CNT_MAX) ? CNT_MAX : exp_cnt_a + int'(o[1]);
            exp_cnt_b = (exp_cnt_b + int'(o[0]) > CNT_MAX) ? CNT_MAX : exp_cnt_b + int'(o[0]);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [1:0] op, input logic wen, input int a,
                         input int b, input int c);
        op_fu = op;
        w_rb  = wen;
        ra    = REG_W'(a);
        rb    = REG_W'(b);
        wc    = REG_W'(c);
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        drive(2'b11, 1'b1, 9, 9, 9);
        clr_cnt = 1'b0;
        rst     = 1'b1;
        #1;
        n_checks++;
        if ({out_a, out_b} !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_outs: got %b expected 11", {out_a, out_b});
        end
        tick();
        n_checks++;
        if (fwd_cnt_a !== 0 || fwd_cnt_b !== 0) begin
            n_fail++;
            $display("FAIL reset_cnt: got A=%0d B=%0d expected 0 0", fwd_cnt_a, fwd_cnt_b);
        end
        rst = 1'b0;
    endtask

    task automatic test_sweep();
        int errs;
        logic [1:0] exp;
        errs    = 0;
        clr_cnt = 1'b1;
        for (int v = 0; v < (1 << 15); v++) begin
            drive(v[14:13], v[12], int'(v[11:8]), int'(v[7:4]), int'(v[3:0]));
            #1;
            exp = model_outs();
            n_checks++;
            if ({out_a, out_b} !== exp) begin
                n_fail++;
                errs++;
                if (errs <= 10)
                    $display("FAIL sweep op=%b w=%b ra=%0d rb=%0d wc=%0d: got %b expected %b",
                             op_fu, w_rb, ra, rb, wc, {out_a, out_b}, exp);
            end
        end
        // clear was held through the sweep, keep the model in step
        tick();
        clr_cnt = 1'b0;
    endtask

    task automatic test_both_match();
        drive(2'b11, 1'b1, 5, 5, 5);
        #1;
        n_checks++;
        if ({out_a, out_b} !== 2'b11) begin
            n_fail++;
            $display("FAIL both_match_outs: got %b expected 11", {out_a, out_b});
        end
        repeat (3) tick();
        n_checks++;
        if (fwd_cnt_a !== 8'd3 || fwd_cnt_b !== 8'd3) begin
            n_fail++;
            $display("FAIL both_match_cnt: got A=%0d B=%0d expected 3 3", fwd_cnt_a, fwd_cnt_b);
        end
    endtask

    task automatic test_wrb_gate();
        drive(2'b11, 1'b0, 7, 7, 7);
        #1;
        n_checks++;
        if ({out_a, out_b} !== 2'b00) begin
            n_fail++;
            $display("FAIL wrb_gate_outs: got %b expected 00", {out_a, out_b});
        end
        repeat (2) tick();
        n_checks++;
        if (fwd_cnt_a !== 8'd3 || fwd_cnt_b !== 8'd3) begin
            n_fail++;
            $display("FAIL wrb_gate_hold: got A=%0d B=%0d expected 3 3", fwd_cnt_a, fwd_cnt_b);
        end
    endtask

    task automatic test_op_mask();
        drive(2'b10, 1'b1, 3, 3, 3);
        #1;
        n_checks++;
        if ({out_a, out_b} !== 2'b10) begin
            n_fail++;
            $display("FAIL op_mask_10: got %b expected 10", {out_a, out_b});
        end
        tick();
        drive(2'b01, 1'b1, 3, 3, 3);
        #1;
        n_checks++;
        if ({out_a, out_b} !== 2'b01) begin
            n_fail++;
            $display("FAIL op_mask_01: got %b expected 01", {out_a, out_b});
        end
        tick();
        n_checks++;
        if (fwd_cnt_a !== 8'd4 || fwd_cnt_b !== 8'd4) begin
            n_fail++;
            $display("FAIL op_mask_cnt: got A=%0d B=%0d expected 4 4", fwd_cnt_a, fwd_cnt_b);
        end
    endtask

    task automatic test_clear();
        drive(2'b10, 1'b1, 6, 1, 6);
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        n_checks++;
        if (fwd_cnt_a !== 0 || fwd_cnt_b !== 0) begin
            n_fail++;
            $display("FAIL clear_wins: got A=%0d B=%0d expected 0 0", fwd_cnt_a, fwd_cnt_b);
        end
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (fwd_cnt_a !== 0 || fwd_cnt_b !== 0) begin
            n_fail++;
            $display("FAIL reset_midrun: got A=%0d B=%0d expected 0 0", fwd_cnt_a, fwd_cnt_b);
        end
    endtask

    task automatic test_saturate();
        drive(2'b10, 1'b1, 2, 0, 2);
        repeat (CNT_MAX) tick();
        n_checks++;
        if (fwd_cnt_a !== CNT_W'(CNT_MAX)) begin
            n_fail++;
            $display("FAIL sat_reach: got %0d expected %0d", fwd_cnt_a, CNT_MAX);
        end
        repeat (5) tick();
        n_checks++;
        if (fwd_cnt_a !== CNT_W'(CNT_MAX) || fwd_cnt_b !== 0) begin
            n_fail++;
            $display("FAIL sat_hold: got A=%0d B=%0d expected %0d 0", fwd_cnt_a, fwd_cnt_b, CNT_MAX);
        end
        // B saturates independently while A stays pinned
        drive(2'b11, 1'b1, 4, 4, 4);
        repeat (CNT_MAX + 3) tick();
        n_checks++;
        if (fwd_cnt_a !== CNT_W'(CNT_MAX) || fwd_cnt_b !== CNT_W'(CNT_MAX)) begin
            n_fail++;
            $display("FAIL sat_both: got A=%0d B=%0d expected %0d %0d",
                     fwd_cnt_a, fwd_cnt_b, CNT_MAX, CNT_MAX);
        end
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
    endtask

    task automatic test_zero_reg();
        logic [1:0] exp;
        exp = zero_reg_on() ? 2'b00 : 2'b11;
        drive(2'b11, 1'b1, 0, 0, 0);
        #1;
        n_checks++;
        if ({out_a, out_b} !== exp) begin
            n_fail++;
            $display("FAIL zero_reg_outs: got %b expected %b", {out_a, out_b}, exp);
        end
        repeat (2) tick();
        n_checks++;
        if (fwd_cnt_a !== CNT_W'(exp_cnt_a) || fwd_cnt_b !== CNT_W'(exp_cnt_b)) begin
            n_fail++;
            $display("FAIL zero_reg_cnt: got A=%0d B=%0d expected %0d %0d",
                     fwd_cnt_a, fwd_cnt_b, exp_cnt_a, exp_cnt_b);
        end
    endtask

    // Random traffic, small index range so matches are frequent.
    task automatic test_random();
        logic [1:0] exp;
        int errs;
        errs = 0;
        for (int i = 0; i < 2000; i++) begin
            drive(2'($urandom_range(3)), 1'($urandom_range(1)),
                  int'($urandom_range(3)), int'($urandom_range(3)), int'($urandom_range(3)));
            clr_cnt = ($urandom_range(49) == 0);
            rst     = ($urandom_range(99) == 0);
            exp_q.push_back(model_outs());
            #1;
            exp = exp_q.pop_front();
            n_checks++;
            if ({out_a, out_b} !== exp) begin
                n_fail++;
                errs++;
                if (errs <= 10)
                    $display("FAIL rand_outs[%0d]: got %b expected %b", i, {out_a, out_b}, exp);
            end
            tick();
            n_checks++;
            if (fwd_cnt_a !== CNT_W'(exp_cnt_a) || fwd_cnt_b !== CNT_W'(exp_cnt_b)) begin
                n_fail++;
                errs++;
                if (errs <= 10)
                    $display("FAIL rand_cnt[%0d]: got A=%0d B=%0d expected %0d %0d",
                             i, fwd_cnt_a, fwd_cnt_b, exp_cnt_a, exp_cnt_b);
            end
        end
        rst     = 1'b0;
        clr_cnt = 1'b0;
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        rst     = 1'b1;
        clr_cnt = 1'b0;
        drive(2'b00, 1'b0, 0, 0, 0);
        @(negedge clk);
        test_reset();
        test_sweep();
        test_both_match();
        test_wrb_gate();
        test_op_mask();
        test_clear();
        test_saturate();
        test_zero_reg();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
